// File: rtl/game_pkg.sv
// Shared types and defaults for the duck round scheduler.
// The optional feature is selected with the DUCK_SPEED_RAMP_EN macro.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FLYING,
    HIT_PAUSE,
    ESCAPE,
    ROUND_CHECK,
    FINISHED
  } state_e;

  localparam int unsigned DUCKS_PER_ROUND_DEF    = 10;
  localparam int unsigned SHOTS_PER_DUCK_DEF     = 3;
  localparam int unsigned MIN_HITS_DEF           = 6;
  localparam int unsigned MAX_ROUNDS_DEF         = 15;
  localparam int unsigned FLY_TIMEOUT_FRAMES_DEF = 300;
  localparam int unsigned PAUSE_FRAMES_DEF       = 60;
  localparam int unsigned POINTS_PER_HIT_DEF     = 100;

  localparam int SCORE_W     = 16;
  localparam int FRAME_CNT_W = 9;

  // Flight timeout shrink per round when the speed ramp is built in.
  localparam int unsigned RAMP_STEP_FRAMES  = 16;
  localparam int unsigned RAMP_FLOOR_FRAMES = 120;

  // Score addition that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  // Flight timeout for a given round: base minus 16 frames per completed round, floored.
  function automatic logic [FRAME_CNT_W-1:0] ramp_timeout(input logic [FRAME_CNT_W-1:0] base,
                                                          input logic [7:0]             round);
    logic [15:0] shrink;
    logic [15:0] base_w;
    base_w = 16'(base);
    shrink = (round == 8'd0) ? 16'd0 : (16'(round) - 16'd1) * 16'(RAMP_STEP_FRAMES);
    if (base_w < shrink + 16'(RAMP_FLOOR_FRAMES)) begin
      return FRAME_CNT_W'(RAMP_FLOOR_FRAMES);
    end
    return FRAME_CNT_W'(base_w - shrink);
  endfunction

endpackage

// File: rtl/click_edge_detect.sv
// One register stage on the mouse button level and a rising-edge pulse.
// The pulse is combinational; the consumer registers whatever it derives from it.
module click_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic rise_pulse
);

  logic level_q;
  logic level_d;

  // Next value of the delayed button level.
  always_comb begin
    level_d = level_in;
  end

  // Delay register for edge detection.
  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign rise_pulse = level_in & ~level_q;

endmodule

// File: rtl/duck_round_scheduler.sv
// Gameplay sequencer: spawns ducks, counts shots/hits/flight time, groups ducks
// into rounds and raises game_finished. Define DUCK_SPEED_RAMP_EN to add the
// duck_speed output and the per-round flight timeout shrink.
module duck_round_scheduler
  import game_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND    = DUCKS_PER_ROUND_DEF,
  parameter int unsigned SHOTS_PER_DUCK     = SHOTS_PER_DUCK_DEF,
  parameter int unsigned MIN_HITS           = MIN_HITS_DEF,
  parameter int unsigned MAX_ROUNDS         = MAX_ROUNDS_DEF,
  parameter int unsigned FLY_TIMEOUT_FRAMES = FLY_TIMEOUT_FRAMES_DEF,
  parameter int unsigned PAUSE_FRAMES       = PAUSE_FRAMES_DEF,
  parameter int unsigned POINTS_PER_HIT     = POINTS_PER_HIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        frame_tick,
  input  logic        left_mouse,
  input  logic        duck_hit,
  output logic        shot_fire,
  output logic        duck_spawn,
  output logic        duck_active,
  output logic        duck_fly_away,
  output logic [1:0]  shots_left,
  output logic [3:0]  hits_in_round,
  output logic [7:0]  round_num,
  output logic [15:0] score,
  output logic        game_finished
`ifdef DUCK_SPEED_RAMP_EN
  ,
  output logic [3:0]  duck_speed
`endif
);

  localparam logic [3:0]             DUCKS_C    = 4'(DUCKS_PER_ROUND);
  localparam logic [1:0]             SHOTS_C    = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]             MIN_HITS_C = 4'(MIN_HITS);
  localparam logic [7:0]             MAX_RND_C  = 8'(MAX_ROUNDS);
  localparam logic [FRAME_CNT_W-1:0] FLY_C      = FRAME_CNT_W'(FLY_TIMEOUT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_C    = FRAME_CNT_W'(PAUSE_FRAMES);
  localparam logic [SCORE_W-1:0]     POINTS_C   = SCORE_W'(POINTS_PER_HIT);

  state_e                 state_q, state_d;
  logic [1:0]             shots_left_q, shots_left_d;
  logic [3:0]             hits_q, hits_d;
  logic [7:0]             round_q, round_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [3:0]             duck_cnt_q, duck_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_CNT_W-1:0] fly_limit;
  logic                   shot_fire_q, shot_fire_d;
  logic                   duck_spawn_q, duck_spawn_d;
  logic                   duck_active_q, duck_active_d;
  logic                   fly_away_q, fly_away_d;
  logic                   finished_q, finished_d;
  logic                   click_rise;
`ifdef DUCK_SPEED_RAMP_EN
  logic [3:0]             speed_q, speed_d;
`endif

  click_edge_detect u_click (
    .clk        (clk),
    .rst        (rst),
    .level_in   (left_mouse),
    .rise_pulse (click_rise)
  );

`ifdef DUCK_SPEED_RAMP_EN
  assign fly_limit = ramp_timeout(FLY_C, round_q);
`else
  assign fly_limit = FLY_C;
`endif

  // Next state and gameplay counters.
  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    shots_left_d = shots_left_q;
    hits_d       = hits_q;
    round_d      = round_q;
    score_d      = score_q;
    duck_cnt_d   = duck_cnt_q;
    frame_cnt_d  = frame_cnt_q;
`ifdef DUCK_SPEED_RAMP_EN
    speed_d      = speed_q;
`endif

    case (state_q)
      IDLE: begin
        if (game_enable) begin
          state_d    = SPAWN;
          round_d    = 8'd1;
          score_d    = '0;
          hits_d     = '0;
          duck_cnt_d = '0;
`ifdef DUCK_SPEED_RAMP_EN
          speed_d    = 4'd1;
`endif
        end
      end

      SPAWN: begin
        state_d      = FLYING;
        shots_left_d = SHOTS_C;
        frame_cnt_d  = '0;
      end

      FLYING: begin
        if (shot_fire_q && shots_left_q != 2'd0) begin
          shots_left_d = shots_left_q - 2'd1;
        end
        // A hit wins over both escape causes, including a timeout on the same cycle.
        if (shot_fire_q && duck_hit) begin
          state_d     = HIT_PAUSE;
          hits_d      = hits_q + 4'd1;
          score_d     = sat_add(score_q, POINTS_C);
          frame_cnt_d = '0;
        end else if (shot_fire_q && shots_left_q == 2'd1) begin
          state_d     = ESCAPE;
          frame_cnt_d = '0;
        end else if (frame_tick) begin
          if (frame_cnt_q == fly_limit - 1'b1) begin
            state_d     = ESCAPE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      HIT_PAUSE, ESCAPE: begin
        if (frame_tick) begin
          if (frame_cnt_q == PAUSE_C - 1'b1) begin
            frame_cnt_d = '0;
            duck_cnt_d  = duck_cnt_q + 4'd1;
            state_d     = (duck_cnt_q + 4'd1 < DUCKS_C) ? SPAWN : ROUND_CHECK;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ROUND_CHECK: begin
        if (hits_q < MIN_HITS_C || round_q == MAX_RND_C) begin
          state_d = FINISHED;
        end else begin
          state_d    = SPAWN;
          round_d    = round_q + 8'd1;
          hits_d     = '0;
          duck_cnt_d = '0;
`ifdef DUCK_SPEED_RAMP_EN
          speed_d    = (speed_q == 4'd15) ? 4'd15 : speed_q + 4'd1;
`endif
        end
      end

      FINISHED: begin
        if (!game_enable) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Dropping game_enable mid-game abandons it; FINISHED keeps its results for the game-over screen.
    if (!game_enable && state_q != IDLE && state_q != FINISHED) begin
      state_d      = IDLE;
      shots_left_d = '0;
      hits_d       = '0;
      round_d      = '0;
      score_d      = '0;
      duck_cnt_d   = '0;
      frame_cnt_d  = '0;
`ifdef DUCK_SPEED_RAMP_EN
      speed_d      = '0;
`endif
    end
  end

  // Registered output values, decoded from the state being entered.
  always_comb begin
    shot_fire_d   = click_rise && state_q == FLYING && shots_left_q != 2'd0 && game_enable;
    duck_spawn_d  = (state_d == SPAWN);
    duck_active_d = (state_d == FLYING);
    fly_away_d    = (state_d == ESCAPE);
    finished_d    = (state_d == FINISHED);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shots_left_q  <= '0;
      hits_q        <= '0;
      round_q       <= '0;
      score_q       <= '0;
      duck_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      shot_fire_q   <= 1'b0;
      duck_spawn_q  <= 1'b0;
      duck_active_q <= 1'b0;
      fly_away_q    <= 1'b0;
      finished_q    <= 1'b0;
`ifdef DUCK_SPEED_RAMP_EN
      speed_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      shots_left_q  <= shots_left_d;
      hits_q        <= hits_d;
      round_q       <= round_d;
      score_q       <= score_d;
      duck_cnt_q    <= duck_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      shot_fire_q   <= shot_fire_d;
      duck_spawn_q  <= duck_spawn_d;
      duck_active_q <= duck_active_d;
      fly_away_q    <= fly_away_d;
      finished_q    <= finished_d;
`ifdef DUCK_SPEED_RAMP_EN
      speed_q       <= speed_d;
`endif
    end
  end

  assign shot_fire     = shot_fire_q;
  assign duck_spawn    = duck_spawn_q;
  assign duck_active   = duck_active_q;
  assign duck_fly_away = fly_away_q;
  assign shots_left    = shots_left_q;
  assign hits_in_round = hits_q;
  assign round_num     = round_q;
  assign score         = score_q;
  assign game_finished = finished_q;
`ifdef DUCK_SPEED_RAMP_EN
  assign duck_speed    = speed_q;
`endif

endmodule

// File: tb/tb_duck_round_scheduler.sv
// Self-checking bench for duck_round_scheduler: a spec-level reference model,
// a short vector table, directed corner sequences and a randomized run.
module tb_duck_round_scheduler;

  localparam int PAUSE      = 60;
  localparam int FLY        = 300;
  localparam int POINTS     = 100;
  localparam int SAT_POINTS = 30000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_enable = 1'b0;
  logic frame_tick  = 1'b0;
  logic left_mouse  = 1'b0;
  logic duck_hit    = 1'b0;

  logic        shot_fire, duck_spawn, duck_active, duck_fly_away, game_finished;
  logic [1:0]  shots_left;
  logic [3:0]  hits_in_round;
  logic [7:0]  round_num;
  logic [15:0] score;

  logic        s_shot_fire, s_duck_spawn, s_duck_active, s_duck_fly_away, s_game_finished;
  logic [1:0]  s_shots_left;
  logic [3:0]  s_hits_in_round;
  logic [7:0]  s_round_num;
  logic [15:0] s_score;
`ifdef DUCK_SPEED_RAMP_EN
  logic [3:0]  duck_speed, s_duck_speed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  duck_round_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .game_enable   (game_enable),
    .frame_tick    (frame_tick),
    .left_mouse    (left_mouse),
    .duck_hit      (duck_hit),
    .shot_fire     (shot_fire),
    .duck_spawn    (duck_spawn),
    .duck_active   (duck_active),
    .duck_fly_away (duck_fly_away),
    .shots_left    (shots_left),
    .hits_in_round (hits_in_round),
    .round_num     (round_num),
    .score         (score),
    .game_finished (game_finished)
`ifdef DUCK_SPEED_RAMP_EN
    , .duck_speed  (duck_speed)
`endif
  );

  // Second copy with a large per-hit score so saturation is reached in a few hits.
  duck_round_scheduler #(.POINTS_PER_HIT(SAT_POINTS)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .game_enable   (game_enable),
    .frame_tick    (frame_tick),
    .left_mouse    (left_mouse),
    .duck_hit      (duck_hit),
    .shot_fire     (s_shot_fire),
    .duck_spawn    (s_duck_spawn),
    .duck_active   (s_duck_active),
    .duck_fly_away (s_duck_fly_away),
    .shots_left    (s_shots_left),
    .hits_in_round (s_hits_in_round),
    .round_num     (s_round_num),
    .score         (s_score),
    .game_finished (s_game_finished)
`ifdef DUCK_SPEED_RAMP_EN
    , .duck_speed  (s_duck_speed)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_SPAWN, M_FLY, M_HIT, M_ESC, M_CHECK, M_DONE} mphase_e;

  mphase_e m_phase      = M_IDLE;
  bit      m_mouse_prev = 1'b0;
  bit      m_shot       = 1'b0;
  int      m_shots      = 0;
  int      m_hits       = 0;
  int      m_round      = 0;
  int      m_score      = 0;
  int      m_score_s    = 0;
  int      m_ducks      = 0;
  int      m_fly_left   = 0;
  int      m_pause_left = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int timeout_for(input int rnd);
`ifdef DUCK_SPEED_RAMP_EN
    int t;
    t = FLY - 16 * (rnd - 1);
    return (t < 120) ? 120 : t;
`else
    return FLY + 0 * rnd;
`endif
  endfunction

  // Advances the model by one clock using the inputs that were present at the edge.
  task automatic model_step();
    bit click;
    bit next_shot;
    int shots_before;
    click        = left_mouse && !m_mouse_prev;
    next_shot    = click && game_enable && m_phase == M_FLY && m_shots != 0;
    m_mouse_prev = left_mouse;
    shots_before = m_shots;
    if (!game_enable && m_phase != M_IDLE && m_phase != M_DONE) begin
      m_phase = M_IDLE;
      m_shots = 0; m_hits = 0; m_round = 0; m_score = 0; m_score_s = 0; m_ducks = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (game_enable) begin
          m_phase = M_SPAWN; m_round = 1; m_score = 0; m_score_s = 0; m_hits = 0; m_ducks = 0;
        end
        M_SPAWN: begin
          m_shots = 3; m_fly_left = timeout_for(m_round); m_phase = M_FLY;
        end
        M_FLY: begin
          if (m_shot && m_shots > 0) m_shots = m_shots - 1;
          if (m_shot && duck_hit) begin
            m_hits = m_hits + 1;
            m_score = sat16(m_score + POINTS);
            m_score_s = sat16(m_score_s + SAT_POINTS);
            m_pause_left = PAUSE; m_phase = M_HIT;
          end else if (m_shot && shots_before == 1) begin
            m_pause_left = PAUSE; m_phase = M_ESC;
          end else if (frame_tick) begin
            if (m_fly_left == 1) begin
              m_pause_left = PAUSE; m_phase = M_ESC;
            end else begin
              m_fly_left = m_fly_left - 1;
            end
          end
        end
        M_HIT, M_ESC: if (frame_tick) begin
          if (m_pause_left == 1) begin
            m_ducks = m_ducks + 1;
            m_phase = (m_ducks < 10) ? M_SPAWN : M_CHECK;
          end else begin
            m_pause_left = m_pause_left - 1;
          end
        end
        M_CHECK: begin
          if (m_hits < 6 || m_round == 15) begin
            m_phase = M_DONE;
          end else begin
            m_round = m_round + 1; m_hits = 0; m_ducks = 0; m_phase = M_SPAWN;
          end
        end
        M_DONE: if (!game_enable) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
    m_shot = next_shot;
  endtask

  function automatic logic [63:0] dut_vec();
    return {13'd0, shot_fire, duck_spawn, duck_active, duck_fly_away, shots_left,
            hits_in_round, round_num, score, game_finished, s_score};
  endfunction

  function automatic logic [63:0] model_vec();
    return {13'd0, m_shot, m_phase == M_SPAWN, m_phase == M_FLY, m_phase == M_ESC, 2'(m_shots),
            4'(m_hits), 8'(m_round), 16'(m_score), m_phase == M_DONE, 16'(m_score_s)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model and compares on the falling edge.
  task automatic step(input logic t_en, input logic t_tick, input logic t_mouse, input logic t_hit);
    game_enable = t_en;
    frame_tick  = t_tick;
    left_mouse  = t_mouse;
    duck_hit    = t_hit;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic play_duck(input bit do_hit);
    step(1, 0, 0, 0);
    if (do_hit) begin
      step(1, 0, 1, 0);
      step(1, 0, 0, 1);
    end else begin
      repeat (3) begin
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
      end
    end
    repeat (PAUSE) step(1, 1, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, tick, mouse, hit;
    logic        e_spawn, e_active, e_fire;
    logic [1:0]  e_shots;
    logic [3:0]  e_hits;
    logic [7:0]  e_round;
    logic [15:0] e_score;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic mouse_r;
    //             en tk ms ht  spn act fir shots hits round score
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 8'd1, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0, 8'd1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'd0, 8'd1, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd1, 8'd1, 16'd100};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd1, 8'd1, 16'd100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut_vec(), 64'd0);
    rst = 1'b0;

    // Start of game and first duck hit.
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].en, vecs[i].tick, vecs[i].mouse, vecs[i].hit);
      check($sformatf("vec%0d", i),
            {duck_spawn, duck_active, shot_fire, shots_left, hits_in_round, round_num, score},
            {vecs[i].e_spawn, vecs[i].e_active, vecs[i].e_fire, vecs[i].e_shots,
             vecs[i].e_hits, vecs[i].e_round, vecs[i].e_score});
    end

    // Hit pause lasts exactly 60 frame ticks.
    repeat (58) step(1, 1, 0, 0);
    check("no_spawn_before_60th", duck_spawn, 1'b0);
    step(1, 1, 0, 0);
    check("spawn_on_60th_tick", duck_spawn, 1'b1);
    step(1, 0, 0, 0);
    check("shots_reload", {duck_active, shots_left}, {1'b1, 2'd3});

    // Three misses, then a fourth click during the escape.
    step(1, 0, 1, 0);
    check("shot1_fire", shot_fire, 1'b1);
    step(1, 0, 0, 0);
    check("shots_after_1", shots_left, 2'd2);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    check("shots_after_2", shots_left, 2'd1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    check("escape_after_3", {duck_fly_away, duck_active, shots_left}, {1'b1, 1'b0, 2'd0});
    step(1, 0, 1, 0);
    check("no_fourth_shot", shot_fire, 1'b0);
    step(1, 0, 0, 0);
    repeat (PAUSE) step(1, 1, 0, 0);
    check("spawn_after_escape", duck_spawn, 1'b1);

    // Flight timeout on the 300th tick.
    step(1, 0, 0, 0);
    repeat (FLY - 1) step(1, 1, 0, 0);
    check("flying_at_299", {duck_active, duck_fly_away}, 2'b10);
    step(1, 1, 0, 0);
    check("timeout_escape", {duck_active, duck_fly_away}, 2'b01);
    repeat (PAUSE) step(1, 1, 0, 0);

    // Hit arriving together with the 300th tick counts as a hit.
    step(1, 0, 0, 0);
    repeat (FLY - 2) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("fire_at_299", shot_fire, 1'b1);
    step(1, 1, 0, 1);
    check("hit_beats_timeout", {duck_active, duck_fly_away, hits_in_round}, {1'b0, 1'b0, 4'd2});
    repeat (PAUSE) step(1, 1, 0, 0);

    // Ducks 5..10: three more hits, five total -> below quota.
    for (int d = 0; d < 6; d++) play_duck(d % 2 == 0);
    step(1, 0, 0, 0);
    check("finished_below_quota", {game_finished, hits_in_round, score}, {1'b1, 4'd5, 16'd500});
    check("sat_score_game1", s_score, 16'hFFFF);
    step(1, 0, 0, 0);
    check("finished_holds", {game_finished, round_num, score}, {1'b1, 8'd1, 16'd500});
    step(0, 0, 0, 0);
    check("finished_to_idle", game_finished, 1'b0);

    // Second game: six hits advance to round 2.
    step(1, 0, 0, 0);
    check("restart_round1", {duck_spawn, round_num, score}, {1'b1, 8'd1, 16'd0});
    for (int d = 0; d < 10; d++) play_duck(d < 6);
    step(1, 0, 0, 0);
    check("advance_round2", {duck_spawn, round_num, hits_in_round, score}, {1'b1, 8'd2, 4'd0, 16'd600});
    check("sat_score_game2", s_score, 16'hFFFF);

    // Abort mid-flight.
    step(1, 0, 0, 0);
    check("flying_before_abort", duck_active, 1'b1);
    step(0, 0, 0, 0);
    check("abort_all_zero", dut_vec(), 64'd0);

    // Randomized play against the model.
    mouse_r = 1'b0;
    for (int c = 0; c < 8000 && n_fail < 20; c++) begin
      logic r_en;
      if (m_phase == M_DONE) r_en = ($urandom_range(0, 3) != 0);
      else                   r_en = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 2) == 0) mouse_r = ~mouse_r;
      step(r_en, 1'($urandom_range(0, 1)), mouse_r, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
